// File: rtl/seg7_scan_driver.sv
// Eight-digit seven-segment scan driver with dead-time blanking,
// leading-zero suppression and frame-aligned value updates.
module seg7_scan_driver #(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        enable_i,
  input  logic [31:0] value_i,
  input  logic        value_valid_i,
  input  logic [7:0]  dp_mask_i,
  input  logic        blank_lz_i,
  output logic [7:0]  SEG_SEL,
  output logic [7:0]  SEG_DATA,
  output logic        frame_start_o
);

  localparam int CW = $clog2(DIGIT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] BLNK = CW'(BLANK_CYCLES);

  logic [CW-1:0] cnt;
  logic [2:0]    dig;
  logic [31:0]   shadow;
  logic [31:0]   active;

  logic          fs;
  logic [31:0]   act_nx;
  logic [31:0]   upper;
  logic [3:0]    nib;
  logic [6:0]    seg;
  logic          dp;
  logic          lz;
  logic          blank;

  function automatic logic [6:0] hexseg(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
    endcase
    return s;
  endfunction

  // Decode from the value this slot will latch, so a frame-start
  // strobe is visible even with zero blanking cycles.
  always_comb begin
    fs     = enable_i && (cnt == '0) && (dig == 3'd0);
    act_nx = active;
    if (fs) act_nx = value_valid_i ? value_i : shadow;
    upper  = act_nx >> {dig, 2'b00};
    nib    = upper[3:0];
    seg    = hexseg(nib);
    dp     = dp_mask_i[dig];
    lz     = blank_lz_i && (dig != 3'd0)
             && (upper == 32'd0) && !dp;
    blank  = (cnt < BLNK) || lz;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt           <= '0;
      dig           <= 3'd0;
      shadow        <= 32'd0;
      active        <= 32'd0;
      SEG_SEL       <= 8'hFF;
      SEG_DATA      <= 8'hFF;
      frame_start_o <= 1'b0;
    end else begin
      if (value_valid_i) shadow <= value_i;
      if (fs) active <= act_nx;
      frame_start_o <= fs;
      if (!enable_i) begin
        cnt      <= '0;
        dig      <= 3'd0;
        SEG_SEL  <= 8'hFF;
        SEG_DATA <= 8'hFF;
      end else begin
        if (cnt == LAST) begin
          cnt <= '0;
          dig <= dig + 3'd1;
        end else begin
          cnt <= cnt + 1'b1;
        end
        if (blank) begin
          SEG_SEL  <= 8'hFF;
          SEG_DATA <= 8'hFF;
        end else begin
          SEG_SEL  <= ~(8'h01 << dig);
          SEG_DATA <= ~{dp, seg};
        end
      end
    end
  end

endmodule
